// File: rtl/health_tracker.sv
// N-channel health tracker: edge-detected hits/heals, post-hit invincibility,
// saturating health, sticky death, global revive. All state updates on the sampling edge.
module health_tracker #(
  parameter int N          = 2,
  parameter int W          = 8,
  parameter int MAX_HEALTH = 250,
  parameter int DAMAGE     = 20,
  parameter int HEAL_AMT   = 10,
  parameter int INV_CYCLES = 60
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic [N-1:0]   hit,
  input  logic [N-1:0]   heal,
  input  logic           revive,
  output logic [N*W-1:0] health,
  output logic [N-1:0]   dead,
  output logic [N-1:0]   damaged,
  output logic [N-1:0]   invincible,
  output logic [N-1:0]   winner
);

  // A disabled window still needs a 1-bit counter to keep the vector legal.
  localparam int CW = (INV_CYCLES > 0) ? $clog2(INV_CYCLES + 1) : 1;

  localparam logic signed [W+1:0] C_DMG    = (W+2)'(DAMAGE);
  localparam logic signed [W+1:0] C_HEAL   = (W+2)'(HEAL_AMT);
  localparam logic signed [W+1:0] C_MAX_S  = (W+2)'(MAX_HEALTH);
  localparam logic [W-1:0]        C_MAX_U  = W'(MAX_HEALTH);
  localparam logic [CW-1:0]       C_INV    = CW'(INV_CYCLES);
  localparam logic [CW-1:0]       C_ONE    = CW'(1);

  typedef enum logic [1:0] {
    S_READY = 2'd0,
    S_COOL  = 2'd1,
    S_DEAD  = 2'd2
  } state_t;

  state_t        r_state     [N];
  state_t        w_state_nx  [N];
  logic [CW-1:0] r_cnt       [N];
  logic [CW-1:0] w_cnt_nx    [N];
  logic [W-1:0]  r_health    [N];
  logic [W-1:0]  w_health_nx [N];

  logic [N-1:0]  r_hit_d, r_heal_d;
  logic [N-1:0]  r_dead, r_damaged;
  logic [N-1:0]  w_dead_nx, w_damaged_nx;
  logic [N-1:0]  w_hit_rise, w_heal_rise;

  assign w_hit_rise  = hit  & ~r_hit_d;
  assign w_heal_rise = heal & ~r_heal_d;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_hit_d   <= '1;
      r_heal_d  <= '1;
      r_dead    <= '0;
      r_damaged <= '0;
      for (int i = 0; i < N; i++) begin
        r_state[i]  <= S_READY;
        r_cnt[i]    <= '0;
        r_health[i] <= C_MAX_U;
      end
    end else begin
      r_hit_d   <= hit;
      r_heal_d  <= heal;
      r_dead    <= w_dead_nx;
      r_damaged <= w_damaged_nx;
      for (int i = 0; i < N; i++) begin
        r_state[i]  <= w_state_nx[i];
        r_cnt[i]    <= w_cnt_nx[i];
        r_health[i] <= w_health_nx[i];
      end
    end
  end

  always_comb begin
    w_dead_nx    = r_dead;
    w_damaged_nx = '0;
    for (int i = 0; i < N; i++) begin
      logic                w_open;
      logic                w_hit_acc;
      logic                w_heal_acc;
      logic signed [W+1:0] w_sum;

      w_state_nx[i]  = r_state[i];
      w_cnt_nx[i]    = r_cnt[i];
      w_health_nx[i] = r_health[i];

      // The last cooldown cycle already accepts a new hit.
      w_open     = (r_state[i] == S_READY) ||
                   ((r_state[i] == S_COOL) && (r_cnt[i] <= C_ONE));
      w_hit_acc  = w_hit_rise[i] && w_open;
      w_heal_acc = w_heal_rise[i] && (r_state[i] != S_DEAD);

      if (r_state[i] == S_COOL) begin
        if (r_cnt[i] <= C_ONE) begin
          w_state_nx[i] = S_READY;
          w_cnt_nx[i]   = '0;
        end else begin
          w_cnt_nx[i] = r_cnt[i] - C_ONE;
        end
      end

      w_sum = $signed({2'b00, r_health[i]});
      if (w_hit_acc)  w_sum = w_sum - C_DMG;
      if (w_heal_acc) w_sum = w_sum + C_HEAL;

      if (w_hit_acc || w_heal_acc) begin
        if (w_sum <= 0)            w_health_nx[i] = '0;
        else if (w_sum > C_MAX_S)  w_health_nx[i] = C_MAX_U;
        else                       w_health_nx[i] = w_sum[W-1:0];
      end

      if (w_hit_acc) begin
        w_damaged_nx[i] = 1'b1;
        if (w_sum <= 0) begin
          w_dead_nx[i]  = 1'b1;
          w_state_nx[i] = S_DEAD;
          w_cnt_nx[i]   = '0;
        end else if (INV_CYCLES > 0) begin
          w_state_nx[i] = S_COOL;
          w_cnt_nx[i]   = C_INV;
        end
      end

      if (revive) begin
        w_state_nx[i]   = S_READY;
        w_cnt_nx[i]     = '0;
        w_health_nx[i]  = C_MAX_U;
        w_dead_nx[i]    = 1'b0;
        w_damaged_nx[i] = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_out
    assign health[g*W +: W] = r_health[g];
    assign invincible[g]    = (r_state[g] == S_COOL);
  end

  assign dead    = r_dead;
  assign damaged = r_damaged;
  assign winner  = ((N > 1) && ($countones(~r_dead) == 1)) ? ~r_dead : '0;

endmodule

// File: tb/tb_health_tracker.sv
// Randomized + directed bench for health_tracker against an edge-indexed reference model.
module tb_health_tracker;

  localparam int N   = 2;
  localparam int W   = 8;
  localparam int MAXH = 250;
  localparam int DMG = 20;
  localparam int HL  = 10;
  localparam int INV = 4;

  logic           Clk;
  logic           Reset_n;
  logic [N-1:0]   hit, heal;
  logic           revive;
  logic [N*W-1:0] health;
  logic [N-1:0]   dead, damaged, invincible, winner;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: hits are accepted at edge e when e >= m_ok (first edge after the window).
  int           m_hp   [N];
  bit           m_dead [N];
  bit           m_dmg  [N];
  int           m_ok   [N];
  logic [N-1:0] m_phit, m_pheal;
  int           e_idx;

  health_tracker #(
    .N(N), .W(W), .MAX_HEALTH(MAXH), .DAMAGE(DMG), .HEAL_AMT(HL), .INV_CYCLES(INV)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .hit(hit), .heal(heal), .revive(revive),
    .health(health), .dead(dead), .damaged(damaged), .invincible(invincible),
    .winner(winner)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_hp[i]   = MAXH;
      m_dead[i] = 1'b0;
      m_dmg[i]  = 1'b0;
      m_ok[i]   = -1;
    end
    m_phit  = '1;
    m_pheal = '1;
    e_idx   = 0;
  endtask

  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      bit rh, rl, acc;
      int s;
      rh = hit[i]  && !m_phit[i];
      rl = heal[i] && !m_pheal[i];
      m_dmg[i] = 1'b0;
      if (revive) begin
        m_hp[i]   = MAXH;
        m_dead[i] = 1'b0;
        m_ok[i]   = -1;
      end else if (!m_dead[i]) begin
        acc = rh && (e_idx >= m_ok[i]);
        s   = m_hp[i] - (acc ? DMG : 0) + (rl ? HL : 0);
        if (s < 0)    s = 0;
        if (s > MAXH) s = MAXH;
        m_hp[i] = s;
        if (acc) begin
          m_dmg[i] = 1'b1;
          if (s == 0) m_dead[i] = 1'b1;
          else        m_ok[i]   = e_idx + INV;
        end
      end
    end
    m_phit  = hit;
    m_pheal = heal;
    e_idx++;
  endtask

  task automatic check_all();
    logic [N-1:0] xd, xg, xi, xw;
    int alive;
    alive = 0;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("health%0d", i), 32'(health[i*W +: W]), 32'(m_hp[i]));
      xd[i] = m_dead[i];
      xg[i] = m_dmg[i];
      xi[i] = !m_dead[i] && (e_idx <= m_ok[i]);
      if (!m_dead[i]) alive++;
    end
    xw = (N > 1 && alive == 1) ? ~xd : '0;
    chk("dead",       32'(dead),       32'(xd));
    chk("damaged",    32'(damaged),    32'(xg));
    chk("invincible", 32'(invincible), 32'(xi));
    chk("winner",     32'(winner),     32'(xw));
  endtask

  // Called at a falling edge: drive, let one rising edge happen, check at next falling edge.
  task automatic step(input logic [N-1:0] h, input logic [N-1:0] hl, input logic rv);
    hit    = h;
    heal   = hl;
    revive = rv;
    model_edge();
    @(negedge Clk);
    check_all();
  endtask

  // Asserts reset between edges so the outputs are checked with no clock involved.
  task automatic do_reset(input logic [N-1:0] h);
    #2;
    Reset_n = 1'b0;
    hit     = h;
    heal    = '0;
    revive  = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  initial begin
    Reset_n = 1'b0;
    hit     = '0;
    heal    = '0;
    revive  = 1'b0;
    model_reset();
    @(negedge Clk);
    do_reset('0);

    repeat (2) step('0, '0, 1'b0);
    chk("rst_health", 32'(health), 32'({8'd250, 8'd250}));

    // Held hit: single damage, 4-cycle window
    repeat (10) step(2'b01, '0, 1'b0);
    chk("t1_hp0", 32'(health[7:0]), 32'd230);
    chk("t1_hp1", 32'(health[15:8]), 32'd250);
    step('0, '0, 1'b0);

    // Rises every two cycles
    for (int k = 0; k < 8; k++) begin
      step(2'b01, '0, 1'b0);
      step('0, '0, 1'b0);
    end

    // Hit channel 0 to death
    for (int k = 0; k < 20 && !m_dead[0]; k++) begin
      step(2'b01, '0, 1'b0);
      repeat (5) step('0, '0, 1'b0);
    end
    chk("t3_hp0", 32'(health[7:0]), 32'd0);
    chk("t3_dead", 32'(dead), 32'b01);
    chk("t3_winner", 32'(winner), 32'b10);
    step(2'b01, 2'b01, 1'b0);
    step('0, '0, 1'b0);
    step('0, 2'b01, 1'b0);
    chk("t3_stuck", 32'(health[7:0]), 32'd0);

    // Revive on the same edge as a channel-1 hit
    step(2'b10, '0, 1'b1);
    chk("t5_health", 32'(health), 32'({8'd250, 8'd250}));
    chk("t5_dead", 32'(dead), 32'd0);
    chk("t5_dmg", 32'(damaged), 32'd0);
    chk("t5_win", 32'(winner), 32'd0);
    step('0, '0, 1'b0);

    // Heal saturation and simultaneous hit+heal
    step(2'b01, '0, 1'b0);
    repeat (5) step('0, '0, 1'b0);
    step('0, 2'b01, 1'b0);
    step('0, '0, 1'b0);
    step('0, 2'b01, 1'b0);
    chk("t4_sat", 32'(health[7:0]), 32'd250);
    step('0, '0, 1'b0);
    step(2'b01, 2'b01, 1'b0);
    chk("t4_both_hp", 32'(health[7:0]), 32'd240);
    chk("t4_both_dmg", 32'(damaged), 32'b01);
    repeat (5) step('0, '0, 1'b0);

    // Hit held through reset release, then async reset mid-cooldown
    do_reset(2'b01);
    repeat (3) step(2'b01, '0, 1'b0);
    chk("t6_held", 32'(health[7:0]), 32'd250);
    step('0, '0, 1'b0);
    step(2'b01, '0, 1'b0);
    chk("t6_rise", 32'(health[7:0]), 32'd230);
    step('0, '0, 1'b0);
    do_reset('0);
    step('0, '0, 1'b0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] h, hl;
      logic         rv;
      h  = N'($urandom);
      hl = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      rv = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 599) == 0) do_reset(N'($urandom));
      else                             step(h, hl, rv);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
